axi_rd_slice: RTL
=================

Name: axi_rd_slice

Overview:
- Parametrised read-path buffer slice for the AXI VIP. Sits between an upstream manager (s_ side) and a downstream subordinate (m_ side).
- Carries the AR and R channels, with an independently sized FIFO on each.
- Caps outstanding read bursts at MAX_OUTST.
- Successor to the plain wire-level read channels: adds configurable depth, registered decoupling and outstanding-transaction throttling.

Parameters:
ID_W, `D_ID_WIDTH, ARID/RID width
ADDR_W, `D_ADDR_WIDTH, ARADDR width
DATA_W, `D_DATA_WIDTH, RDATA width
AR_DEPTH, 2, AR FIFO entries; power of 2, >=2
R_DEPTH, 4, R FIFO entries; power of 2, >=2
MAX_OUTST, 4, maximum issued-but-not-completed bursts; 1..255

Ports:
ACLK  in  1  clock, all logic on rising edge
ARSETn  in  1  asynchronous active-low reset
s_ar_valid  in  1  upstream AR valid
s_ar_ready  out  1  upstream AR ready
s_ar_pld  in  AR_PLD_W  packed {ARID,ARADDR,ARLEN,ARSIZE,ARBURST,ARPROT}; AR_PLD_W=ID_W+ADDR_W+16
m_ar_valid  out  1  downstream AR valid
m_ar_ready  in  1  downstream AR ready
m_ar_pld  out  AR_PLD_W  AR payload, same packing
m_r_valid  in  1  downstream R valid
m_r_ready  out  1  downstream R ready
m_r_pld  in  R_PLD_W  packed {RID,RDATA,RRESP,RLAST}, RLAST at bit 0; R_PLD_W=ID_W+DATA_W+3
s_r_valid  out  1  upstream R valid
s_r_ready  in  1  upstream R ready
s_r_pld  out  R_PLD_W  R payload, same packing
outst_cnt  out  8  bursts currently outstanding

Behaviour:
- Reset (ARSETn low, asynchronous):
  - All ready and valid outputs go to 0; outst_cnt goes to 0; FIFO pointers clear.
  - Payload outputs are don't-care.
  - Reset mid-burst silently drops all buffered beats and the outstanding count.
- Readies are registered.
  - s_ar_ready = !ar_full and m_r_ready = !r_full.
  - Both rise on the first ACLK edge after ARSETn deasserts.
- Handshake: a transfer occurs when valid&&ready at a rising edge. valid is never withdrawn without a handshake, and payload holds stable while valid&&!ready.
- FIFO latency: an entry pushed at edge N is presented (valid=1) after edge N; minimum 1-cycle pass-through.
- Full FIFO: ready is 0; the next-cycle ready reflects a same-cycle pop. Full throughput is 1 beat/cycle once DEPTH>=2.
- Empty FIFO: output valid is 0; push and pop never coincide on an empty entry.
- Throttle: m_ar_valid = !ar_empty && (outst_cnt < MAX_OUTST).
- outst_cnt:
  - +1 on m_ar handshake.
  - -1 on s_r handshake with RLAST=1.
  - Both in the same cycle leaves it unchanged.
- Saturation: an increment at MAX_OUTST cannot occur because of the throttle. A decrement at 0 (stray RLAST) holds 0 and is flagged by a VIP assertion.
- Data is never reordered; RID is passed through untouched.

Optional Feature:
- Macro AXI_RD_SLICE_STAT_EN.
- When defined: extra outputs stat_beats (32 bit, counts s_r handshakes) and stat_throttle (32 bit, counts cycles with !ar_empty && outst_cnt==MAX_OUTST). Both wrap modulo 2^32 and reset to 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package axi_pkg holds:
  - AR_PLD_W / R_PLD_W localparam functions;
  - ar_pld_t and r_pld_t packed structs matching the packing above;
  - burst/resp enums: BURST_FIXED=0, INCR=1, WRAP=2; RESP_OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
- Sub-module axi_chan_fifo (WIDTH, DEPTH) provides valid/ready in and out, registered ready, and a count output. It is instantiated twice: AR and R.

Test Plan:
- Single read ARLEN=3, m_ar_ready=1, R beats back-to-back, s_r_ready=1 -> AR appears on m_ 1 cycle after s_ accept; 4 beats upstream in order with RLAST on the 4th; outst_cnt goes 0->1->0.
- MAX_OUTST=2, issue 3 ARs with no R returned -> m_ar_valid drops after the 2nd handshake and outst_cnt=2; the 3rd issues the cycle after the first RLAST delivered upstream.
- R_DEPTH=4, s_r_ready=0, 6 beats offered downstream -> m_r_ready=0 after the 4th push; beats 5-6 are held stable, then drain in order when s_r_ready=1.
- Same-cycle m_ar handshake and final RLAST at outst_cnt=1 -> outst_cnt stays 1.
- ARSETn pulsed low mid-burst (2 of 4 beats buffered) -> valids, readies and outst_cnt are 0 immediately; readies return to 1 one edge after release; no stale beat appears.
- With AXI_RD_SLICE_STAT_EN: 8 beats plus 5 throttled cycles -> stat_beats=8, stat_throttle=5.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI read-path types, enums and width helpers.
// Default widths come from the D_*_WIDTH macros unless the build sets them.
`ifndef D_ID_WIDTH
`define D_ID_WIDTH 4
`endif
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  function automatic int ar_pld_w(int id_w, int addr_w);
    return id_w + addr_w + 16;
  endfunction

  function automatic int r_pld_w(int id_w, int data_w);
    return id_w + data_w + 3;
  endfunction

  typedef struct packed {
    logic [`D_ID_WIDTH-1:0]   id;
    logic [`D_ADDR_WIDTH-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    burst_e                   burst;
    logic [2:0]               prot;
  } ar_pld_t;

  typedef struct packed {
    logic [`D_ID_WIDTH-1:0]   id;
    logic [`D_DATA_WIDTH-1:0] data;
    resp_e                    resp;
    logic                     last;
  } r_pld_t;

endpackage

// File: rtl/axi_chan_fifo.sv
// axi_chan_fifo: valid/ready channel FIFO with registered in_ready.
// Ready is computed from the next occupancy so a same-cycle pop frees space.
module axi_chan_fifo
  import axi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // Occupancy after this edge.
  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      push && !pop: count_nxt = count + CW'(1);
      pop && !push: count_nxt = count - CW'(1);
      default:      count_nxt = count;
    endcase
  end

  // Pointers, occupancy and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      in_ready <= (count_nxt != CW'(DEPTH));
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/axi_rd_slice.sv
// axi_rd_slice: AR/R buffer slice with outstanding-burst throttle.
// Define AXI_RD_SLICE_STAT_EN to add stat_beats / stat_throttle counters.
`ifndef D_ID_WIDTH
`define D_ID_WIDTH 4
`endif
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

module axi_rd_slice
  import axi_pkg::*;
#(
  parameter int ID_W      = `D_ID_WIDTH,
  parameter int ADDR_W    = `D_ADDR_WIDTH,
  parameter int DATA_W    = `D_DATA_WIDTH,
  parameter int AR_DEPTH  = 2,
  parameter int R_DEPTH   = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                              ACLK,
  input  logic                              ARSETn,
  input  logic                              s_ar_valid,
  output logic                              s_ar_ready,
  input  logic [ar_pld_w(ID_W,ADDR_W)-1:0]  s_ar_pld,
  output logic                              m_ar_valid,
  input  logic                              m_ar_ready,
  output logic [ar_pld_w(ID_W,ADDR_W)-1:0]  m_ar_pld,
  input  logic                              m_r_valid,
  output logic                              m_r_ready,
  input  logic [r_pld_w(ID_W,DATA_W)-1:0]   m_r_pld,
  output logic                              s_r_valid,
  input  logic                              s_r_ready,
  output logic [r_pld_w(ID_W,DATA_W)-1:0]   s_r_pld,
  output logic [7:0]                        outst_cnt
`ifdef AXI_RD_SLICE_STAT_EN
  ,
  output logic [31:0]                       stat_beats,
  output logic [31:0]                       stat_throttle
`endif
);

  localparam int AR_W = ar_pld_w(ID_W, ADDR_W);
  localparam int R_W  = r_pld_w(ID_W, DATA_W);
  localparam logic [7:0] MAX_C = 8'(MAX_OUTST);

  logic                          ar_head;
  logic                          room;
  logic                          ar_pop_ok;
  logic                          ar_hs;
  logic                          last_hs;
  logic [$clog2(AR_DEPTH+1)-1:0] ar_cnt_unused;
  logic [$clog2(R_DEPTH+1)-1:0]  r_cnt_unused;

  assign room       = (outst_cnt < MAX_C);
  assign m_ar_valid = ar_head && room;
  assign ar_pop_ok  = m_ar_ready && room;
  assign ar_hs      = m_ar_valid && m_ar_ready;
  assign last_hs    = s_r_valid && s_r_ready && s_r_pld[0];

  axi_chan_fifo #(.WIDTH(AR_W), .DEPTH(AR_DEPTH)) u_ar (
    .clk       (ACLK),
    .rst_n     (ARSETn),
    .in_valid  (s_ar_valid),
    .in_ready  (s_ar_ready),
    .in_data   (s_ar_pld),
    .out_valid (ar_head),
    .out_ready (ar_pop_ok),
    .out_data  (m_ar_pld),
    .count     (ar_cnt_unused)
  );

  axi_chan_fifo #(.WIDTH(R_W), .DEPTH(R_DEPTH)) u_r (
    .clk       (ACLK),
    .rst_n     (ARSETn),
    .in_valid  (m_r_valid),
    .in_ready  (m_r_ready),
    .in_data   (m_r_pld),
    .out_valid (s_r_valid),
    .out_ready (s_r_ready),
    .out_data  (s_r_pld),
    .count     (r_cnt_unused)
  );

  // Outstanding bursts: issue adds one, delivered RLAST removes one.
  always_ff @(posedge ACLK or negedge ARSETn) begin
    if (!ARSETn) begin
      outst_cnt <= '0;
    end else if (ar_hs && !last_hs) begin
      outst_cnt <= outst_cnt + 8'd1;
    end else if (last_hs && !ar_hs && outst_cnt != '0) begin
      outst_cnt <= outst_cnt - 8'd1;
    end
  end

`ifdef AXI_RD_SLICE_STAT_EN
  // Delivered-beat and throttled-cycle counters, free-running wrap.
  always_ff @(posedge ACLK or negedge ARSETn) begin
    if (!ARSETn) begin
      stat_beats    <= '0;
      stat_throttle <= '0;
    end else begin
      if (s_r_valid && s_r_ready)
        stat_beats <= stat_beats + 32'd1;
      if (ar_head && outst_cnt == MAX_C)
        stat_throttle <= stat_throttle + 32'd1;
    end
  end
`endif

endmodule
